// File: rtl/audio_buf_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : audio_buf_pkg
// Description : Shared types and constants for the audio sample buffer
//               (sample width, default buffer address width, occupancy
//               classification used by the pointer/flag controller).
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
package audio_buf_pkg;

  localparam int SAMPLE_W = 24;
  localparam int BUF_AW   = 4;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Coarse occupancy class of the buffer, decoded from the pointer pair.
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_t;

endpackage : audio_buf_pkg
`default_nettype wire

// File: rtl/fifo_ptr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : fifo_ptr
// Description : Free-running incrementing pointer with enable and
//               synchronous active-high reset. The caller passes one bit
//               more than the buffer address width so the MSB acts as the
//               wrap bit; rollover is the natural modulo-2**WIDTH wrap.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module fifo_ptr #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] ptr
);

  logic [WIDTH-1:0] r_ptr;

  // Pointer register: cleared by reset, otherwise advances by one when enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (en) begin
      r_ptr <= r_ptr + WIDTH'(1);
    end
  end

  assign ptr = r_ptr;

endmodule : fifo_ptr
`default_nettype wire

// File: rtl/fifo_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : fifo_ctrl
// Description : Pointer/flag controller for the circular audio sample
//               buffer. Drives the register file write enable and the
//               write/read addresses, reports occupancy and level flags,
//               and holds sticky overflow/underflow error flags. The read
//               address is the head, so with an asynchronous-read register
//               file the head sample is presented first-word-fall-through.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module fifo_ctrl
  import audio_buf_pkg::*;
#(
  parameter int ADDR_WIDTH = BUF_AW,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic                  rd_req,
  input  logic                  clr_err,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] C_AFULL  = (ADDR_WIDTH+1)'(AFULL_LVL);
  localparam logic [ADDR_WIDTH:0] C_AEMPTY = (ADDR_WIDTH+1)'(AEMPTY_LVL);

  logic [ADDR_WIDTH:0] w_wr_ptr;
  logic [ADDR_WIDTH:0] w_rd_ptr;
  occ_state_t          w_occ;
  logic                w_do_wr;
  logic                w_do_rd;
  logic                w_rej_wr;
  logic                w_rej_rd;
  logic                r_overflow;
  logic                r_underflow;

  // Tail pointer: advances on every accepted push.
  fifo_ptr #(
    .WIDTH (ADDR_WIDTH+1)
  ) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .en    (w_do_wr),
    .ptr   (w_wr_ptr)
  );

  // Head pointer: advances on every accepted pop.
  fifo_ptr #(
    .WIDTH (ADDR_WIDTH+1)
  ) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .en    (w_do_rd),
    .ptr   (w_rd_ptr)
  );

  // Classify occupancy from the pointer pair: identical pointers mean empty,
  // same slot but different wrap bit means every slot holds a sample.
  always_comb begin
    w_occ = OCC_PARTIAL;
    if (w_wr_ptr == w_rd_ptr) begin
      w_occ = OCC_EMPTY;
    end else if (w_wr_ptr[ADDR_WIDTH-1:0] == w_rd_ptr[ADDR_WIDTH-1:0]) begin
      w_occ = OCC_FULL;
    end
  end

  // Status outputs depend only on the registered pointers.
  assign empty        = (w_occ == OCC_EMPTY);
  assign full         = (w_occ == OCC_FULL);
  assign count        = w_wr_ptr - w_rd_ptr;
  assign almost_full  = (count >= C_AFULL);
  assign almost_empty = (count <= C_AEMPTY);
  assign w_addr       = w_wr_ptr[ADDR_WIDTH-1:0];
  assign r_addr       = w_rd_ptr[ADDR_WIDTH-1:0];

  // Request acceptance. A pop frees the head slot in the same cycle, so a
  // push into a full buffer is still accepted when paired with a pop; the
  // head is read asynchronously before the edge overwrites that slot.
  assign w_do_rd  = rd_req & ~empty & ~reset;
  assign w_do_wr  = wr_req & (~full | w_do_rd) & ~reset;
  assign w_rej_wr = wr_req & ~w_do_wr;
  assign w_rej_rd = rd_req & empty;
  assign w_en     = w_do_wr;

  // Sticky error flags: a new error in the same cycle as clr_err wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_rej_wr) begin
        r_overflow <= 1'b1;
      end else if (clr_err) begin
        r_overflow <= 1'b0;
      end
      if (w_rej_rd) begin
        r_underflow <= 1'b1;
      end else if (clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule : fifo_ctrl
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_fifo_ctrl
// Description : Self-checking bench for fifo_ctrl with a local register
//               file model, a queue-based reference buffer and a
//               scoreboard monitor for the head samples.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_fifo_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFL   = 12;
  localparam int AEL   = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_req;
  logic          rd_req;
  logic          clr_err;
  logic          w_en;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] r_addr;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  logic [23:0]   wr_data;
  logic [23:0]   mem [DEPTH];
  logic [23:0]   r_data;

  int errors = 0;
  int checks = 0;

  // Reference buffer state
  logic [23:0] mq[$];
  logic [23:0] exp_q[$];
  bit          m_ovf;
  bit          m_unf;
  int          wr_total;
  int          rd_total;

  fifo_ctrl #(
    .ADDR_WIDTH (AW),
    .AFULL_LVL  (AFL),
    .AEMPTY_LVL (AEL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_req       (wr_req),
    .rd_req       (rd_req),
    .clr_err      (clr_err),
    .w_en         (w_en),
    .w_addr       (w_addr),
    .r_addr       (r_addr),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  // Register file: synchronous write, asynchronous read.
  always @(posedge clk) if (w_en) mem[w_addr] <= wr_data;
  assign r_data = mem[r_addr];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: whenever the DUT presents a head sample being
  // consumed, compare it with the oldest expected sample.
  always @(negedge clk) begin
    if (reset === 1'b0 && rd_req === 1'b1 && empty === 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 1, 0);
      end else begin
        chk("r_data", int'(r_data), int'(exp_q.pop_front()));
      end
    end
  end

  // One clock of stimulus: drive, check pre-edge outputs, advance the model.
  task automatic cycle(input bit wr, input bit rd, input bit clr, input bit rst,
                       input logic [23:0] d);
    int  n;
    bit  acc_rd, acc_wr;
    reset = rst; wr_req = wr; rd_req = rd; clr_err = clr; wr_data = d;
    #1;
    n      = mq.size();
    acc_rd = !rst && rd && n > 0;
    acc_wr = !rst && wr && (n < DEPTH || acc_rd);
    chk("count",        int'(count),        n);
    chk("empty",        int'(empty),        int'(n == 0));
    chk("full",         int'(full),         int'(n == DEPTH));
    chk("almost_full",  int'(almost_full),  int'(n >= AFL));
    chk("almost_empty", int'(almost_empty), int'(n <= AEL));
    chk("overflow",     int'(overflow),     int'(m_ovf));
    chk("underflow",    int'(underflow),    int'(m_unf));
    chk("w_en",         int'(w_en),         int'(acc_wr));
    chk("w_addr",       int'(w_addr),       wr_total % DEPTH);
    chk("r_addr",       int'(r_addr),       rd_total % DEPTH);
    if (acc_rd) exp_q.push_back(mq[0]);
    @(posedge clk);
    if (rst) begin
      mq.delete(); m_ovf = 0; m_unf = 0; wr_total = 0; rd_total = 0;
    end else begin
      if (acc_rd) begin void'(mq.pop_front()); rd_total++; end
      if (acc_wr) begin mq.push_back(d); wr_total++; end
      if (wr && !acc_wr)    m_ovf = 1; else if (clr) m_ovf = 0;
      if (rd && n == 0)     m_unf = 1; else if (clr) m_unf = 0;
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0; clr_err = 1'b0; wr_data = '0;
    m_ovf = 0; m_unf = 0; wr_total = 0; rd_total = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset held, then idle
    cycle(0, 0, 0, 1, 24'h0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 24'h0);

    // Fill to full with 1..16
    for (int i = 1; i <= DEPTH; i++) cycle(1, 0, 0, 0, 24'(i));
    // Rejected push while full; flag holds, then clears
    cycle(1, 0, 0, 0, 24'hBAD);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 24'h0);
    cycle(0, 0, 1, 0, 24'h0);
    cycle(0, 0, 0, 0, 24'h0);

    // Drain everything, then one extra pop
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 0, 24'h0);
    cycle(0, 1, 0, 0, 24'h0);
    cycle(0, 0, 0, 0, 24'h0);
    // clr_err together with a new underflow: set wins
    cycle(0, 1, 1, 0, 24'h0);
    cycle(0, 0, 1, 0, 24'h0);

    // Push and pop together while empty
    cycle(1, 1, 0, 0, 24'h777);
    cycle(0, 1, 1, 0, 24'h0);

    // Refill, then push+pop for 20 cycles at full across the pointer wrap
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 0, 24'h100 + 24'(i));
    for (int i = 0; i < 20; i++) cycle(1, 1, 0, 0, 24'h200 + 24'(i));
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 0, 24'h0);

    // Reset after 5 pushes, asserted alongside wr_req
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 24'h300 + 24'(i));
    cycle(1, 0, 0, 1, 24'h3FF);
    cycle(0, 0, 0, 0, 24'h0);
    cycle(1, 0, 0, 0, 24'h400);
    cycle(0, 1, 0, 0, 24'h0);

    // Randomized traffic with occasional error clears and resets
    for (int i = 0; i < 400; i++) begin
      cycle(bit'($urandom_range(0, 99) < 55), bit'($urandom_range(0, 99) < 50),
            bit'($urandom_range(0, 99) < 5),  bit'($urandom_range(0, 199) == 0),
            24'($urandom));
    end
    for (int i = 0; i < DEPTH + 1; i++) cycle(0, 1, 0, 0, 24'h0);
    cycle(0, 0, 0, 0, 24'h0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fifo_ctrl
`default_nettype wire
